inst_sequencer: RTL and testbench

- Instruction sequencer feeding the PE-array instruction decoder (`inst_v`/`inst` inputs of the control block).
- Holds a small instruction memory, written by the host. On `start`, issues the stored program one instruction per cycle, with optional repeat count and stall.
- Tracks outstanding write-backs until every issued instruction's `dout_v` has returned, then reports `done`.

---
 rtl/inst_sequencer_pkg.sv | 23 ++
 rtl/inst_mem.sv | 30 +++
 rtl/inst_sequencer.sv | 164 ++++++++++++++++
 tb/tb_inst_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared constants and types for the PE-array instruction sequencer.
// Opcodes occupy bits [31:29] of each instruction word.
package inst_sequencer_pkg;

   localparam int unsigned INST_WIDTH = 32;
   localparam int unsigned WB_LATENCY = 5;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_ADDI = 3'b101;
   localparam logic [2:0] OP_SUBI = 3'b110;
   localparam logic [2:0] OP_MULI = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } seq_state_e;

endpackage

// File: rtl/inst_mem.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
// No reset, so it maps onto block or distributed RAM.
module inst_mem #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_sequencer.sv
// Issues a stored program to the PE-array decoder, optionally repeated, and
// waits for every issued instruction's write-back before pulsing done.
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned INST_W     = INST_WIDTH,
   parameter int unsigned LOOP_WIDTH = 8,
   parameter int unsigned OUT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  prog_we,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [INST_W-1:0]     prog_data,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   input  logic [LOOP_WIDTH-1:0] loop_cnt,
   input  logic                  stall,
   input  logic                  wb_v,
   output logic                  inst_v,
   output logic [INST_W-1:0]     inst,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   seq_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
   logic [LOOP_WIDTH-1:0] iter_q, iter_d;
   logic [LOOP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
   logic [OUT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
   logic                  inst_v_q, inst_v_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  issue;
   logic                  mem_we;
   logic [INST_W-1:0]     mem_rdata;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      end_addr_d = end_addr_q;
      iter_d     = iter_q;
      loop_cnt_d = loop_cnt_q;
      out_cnt_d  = out_cnt_q;
      err_d      = err_q;
      inst_v_d   = 1'b0;
      done_d     = 1'b0;
      issue      = 1'b0;
      mem_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            mem_we = prog_we;
            if (start) begin
               state_d    = StRun;
               pc_d       = '0;
               iter_d     = '0;
               end_addr_d = end_addr;
               loop_cnt_d = loop_cnt;
            end
         end
         StRun: begin
            if (!stall) begin
               issue    = 1'b1;
               inst_v_d = 1'b1;
               if (pc_q != end_addr_q) begin
                  pc_d = pc_q + 1'b1;
               end else if (iter_q < loop_cnt_q) begin
                  pc_d   = '0;
                  iter_d = iter_q + 1'b1;
               end else begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // inst_v_q still high means one increment is about to land
            if (out_cnt_q == '0 && !inst_v_q) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_q != StIdle && (start || prog_we)) begin
         err_d = 1'b1;
      end

      if (inst_v_q && !wb_v) begin
         if (out_cnt_q == '1) begin
            err_d = 1'b1;
         end else begin
            out_cnt_d = out_cnt_q + 1'b1;
         end
      end else if (wb_v && !inst_v_q) begin
         if (out_cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            out_cnt_d = out_cnt_q - 1'b1;
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pc_q       <= '0;
         end_addr_q <= '0;
         iter_q     <= '0;
         loop_cnt_q <= '0;
         out_cnt_q  <= '0;
         inst_v_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         end_addr_q <= end_addr_d;
         iter_q     <= iter_d;
         loop_cnt_q <= loop_cnt_d;
         out_cnt_q  <= out_cnt_d;
         inst_v_q   <= inst_v_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   inst_mem #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(INST_W)
   ) u_inst_mem (
      .clk_i    (clk),
      .wr_en_i  (mem_we),
      .wr_addr_i(prog_addr),
      .wr_data_i(prog_data),
      .rd_en_i  (issue),
      .rd_addr_i(pc_q),
      .rd_data_o(mem_rdata)
   );

   // RAM output is not reset, so mask it outside valid cycles
   assign inst   = inst_v_q ? mem_rdata : '0;
   assign inst_v = inst_v_q;
   assign pc     = pc_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: a reference memory plus a
// write-back delay line model the decoder side.
`timescale 1ns/1ps
module tb_inst_sequencer;
   import inst_sequencer_pkg::*;

   localparam int unsigned AW = 6;
   localparam int unsigned IW = 32;
   localparam int unsigned LW = 8;
   localparam int unsigned OW = 4;

   logic          clk = 1'b0;
   logic          rst, prog_we, start, stall, wb_v;
   logic [AW-1:0] prog_addr, end_addr;
   logic [IW-1:0] prog_data;
   logic [LW-1:0] loop_cnt;
   logic          inst_v, busy, done, err;
   logic [IW-1:0] inst;
   logic [AW-1:0] pc;

   always #5 clk = ~clk;

   inst_sequencer #(
      .ADDR_WIDTH(AW),
      .INST_W    (IW),
      .LOOP_WIDTH(LW),
      .OUT_WIDTH (OW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .prog_we  (prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .start    (start),
      .end_addr (end_addr),
      .loop_cnt (loop_cnt),
      .stall    (stall),
      .wb_v     (wb_v),
      .inst_v   (inst_v),
      .inst     (inst),
      .pc       (pc),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   int            errors = 0;
   int            checks = 0;
   logic [IW-1:0] ref_mem [64];
   logic [IW-1:0] exp_q [$];
   int            exp_pc [$];
   logic [IW-1:0] iss_data [$];
   int            iss_cyc [$];
   logic [AW-1:0] iss_pc [$];
   logic [AW-1:0] pc_log [8192];
   int            cyc = 0;
   int            wb_lat = WB_LATENCY;
   logic [15:0]   wb_pipe = '0;
   logic [AW-1:0] pc_prev = '0;
   int            done_cnt, done_cyc, last_wb_cyc, start_cyc;
   int            stall_mode = 0;

   // One clock: sample outputs just after the edge, then drive wb_v for this cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      pc_log[cyc & 8191] = pc;
      if (inst_v === 1'b1) begin
         iss_data.push_back(inst);
         iss_cyc.push_back(cyc);
         iss_pc.push_back(pc_prev);
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      wb_pipe = {wb_pipe[14:0], (inst_v === 1'b1)};
      wb_v = wb_pipe[wb_lat];
      if (wb_v) last_wb_cyc = cyc;
      pc_prev = pc;
   endtask

   task automatic write_word(input int a, input logic [IW-1:0] d);
      prog_we = 1'b1;
      prog_addr = AW'(a);
      prog_data = d;
      tick();
      prog_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic write_basic_prog();
      write_word(0, {OP_ADD, 29'($urandom)});
      write_word(1, {OP_SUB, 29'($urandom)});
      write_word(2, {OP_MUL, 29'($urandom)});
      write_word(3, {OP_LOAD, 29'($urandom)});
   endtask

   // Expected issue stream: the program body repeated loop_cnt+1 times.
   task automatic build_expected(input int e, input int l);
      exp_q.delete();
      exp_pc.delete();
      for (int it = 0; it <= l; it++)
         for (int a = 0; a <= e; a++) begin
            exp_q.push_back(ref_mem[a]);
            exp_pc.push_back(a);
         end
   endtask

   task automatic launch(input int e, input int l);
      iss_data.delete();
      iss_cyc.delete();
      iss_pc.delete();
      done_cnt = 0;
      done_cyc = -1;
      last_wb_cyc = -1;
      build_expected(e, l);
      end_addr = AW'(e);
      loop_cnt = LW'(l);
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   // Runs until done (bounded) plus a few settle cycles; stall per stall_mode.
   task automatic run_to_done(output bit timed_out);
      int n = 0;
      int stall_left = 0;
      bit stalled_once = 0;
      timed_out = 1'b0;
      while (done_cnt == 0) begin
         if (n > 1000) begin
            timed_out = 1'b1;
            break;
         end
         n++;
         if (stall_mode == 1) begin
            stall = ($urandom_range(0, 3) == 0);
         end else if (stall_mode == 2) begin
            if (!stalled_once && busy && pc == 2) begin
               stall_left = 3;
               stalled_once = 1'b1;
            end
            stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
         end else begin
            stall = 1'b0;
         end
         tick();
      end
      stall = 1'b0;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks += 6;
      if (inst_v !== 1'b0) begin errors++; $display("FAIL reset_inst_v got=%b exp=0", inst_v); end
      if (inst !== '0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
      if (pc !== '0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      bit to;
      write_basic_prog();
      launch(3, 0);
      run_to_done(to);
      checks += 4;
      if (to) begin errors++; $display("FAIL single_timeout got=timeout exp=done"); end
      if (iss_data.size() != 4) begin
         errors++; $display("FAIL single_count got=%0d exp=4", iss_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (iss_data[i] !== exp_q[i] || iss_cyc[i] != start_cyc + 2 + i) begin
               errors++;
               $display("FAIL single_issue%0d got=%h@%0d exp=%h@%0d", i, iss_data[i],
                        iss_cyc[i] - start_cyc, exp_q[i], 2 + i);
            end
         end
      end
      if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
      if (iss_cyc.size() > 0 && done_cyc != last_wb_cyc + 2) begin
         errors++; $display("FAIL single_done_cyc got=%0d exp=%0d", done_cyc, last_wb_cyc + 2);
      end
      if (err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_end got=err%b busy%b exp=err0 busy0", err, busy);
      end
   endtask

   task automatic test_loop();
      bit to;
      launch(3, 2);
      run_to_done(to);
      checks += 3;
      if (to || iss_data.size() != 12) begin
         errors++; $display("FAIL loop_count got=%0d exp=12", iss_data.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (iss_data[i] !== exp_q[i] || int'(iss_pc[i]) != exp_pc[i]) begin
               errors++;
               $display("FAIL loop_issue%0d got=%h pc%0d exp=%h pc%0d", i, iss_data[i],
                        iss_pc[i], exp_q[i], exp_pc[i]);
            end
         end
      end
      if (done_cnt != 1) begin errors++; $display("FAIL loop_done_cnt got=%0d exp=1", done_cnt); end
      if (done_cyc != last_wb_cyc + 2) begin
         errors++; $display("FAIL loop_done_cyc got=%0d exp=%0d", done_cyc, last_wb_cyc + 2);
      end
   endtask

   task automatic test_stall();
      bit to;
      int exp_cyc [4] = '{2, 3, 7, 8};
      stall_mode = 2;
      launch(3, 0);
      run_to_done(to);
      stall_mode = 0;
      checks += 2;
      if (to || iss_data.size() != 4) begin
         errors++; $display("FAIL stall_count got=%0d exp=4", iss_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (iss_data[i] !== exp_q[i] || iss_cyc[i] - start_cyc != exp_cyc[i]) begin
               errors++;
               $display("FAIL stall_issue%0d got=%h@%0d exp=%h@%0d", i, iss_data[i],
                        iss_cyc[i] - start_cyc, exp_q[i], exp_cyc[i]);
            end
         end
      end
      for (int c = 3; c <= 6; c++) begin
         checks++;
         if (pc_log[(start_cyc + c) & 8191] !== AW'(2)) begin
            errors++;
            $display("FAIL stall_pc_hold got=%0d exp=2 at+%0d", pc_log[(start_cyc + c) & 8191], c);
         end
      end
      if (done_cnt != 1) begin errors++; $display("FAIL stall_done_cnt got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_random();
      bit to;
      int e, l;
      stall_mode = 1;
      for (int r = 0; r < 3; r++) begin
         e = $urandom_range(0, 15);
         l = $urandom_range(0, 3);
         for (int a = 0; a <= e; a++) write_word(a, $urandom);
         launch(e, l);
         run_to_done(to);
         checks += 3;
         if (to || iss_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count got=%0d exp=%0d", r, iss_data.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++;
               if (iss_data[i] !== exp_q[i] || int'(iss_pc[i]) != exp_pc[i]) begin
                  errors++;
                  $display("FAIL rand%0d_issue%0d got=%h exp=%h", r, i, iss_data[i], exp_q[i]);
               end
            end
         end
         if (done_cnt != 1 || done_cyc != last_wb_cyc + 2) begin
            errors++;
            $display("FAIL rand%0d_done got=%0d@%0d exp=1@%0d", r, done_cnt, done_cyc,
                     last_wb_cyc + 2);
         end
         if (err !== 1'b0) begin errors++; $display("FAIL rand%0d_err got=%b exp=0", r, err); end
      end
      stall_mode = 0;
   endtask

   task automatic test_busy_err();
      bit to;
      write_basic_prog();
      launch(3, 0);
      tick();
      prog_we = 1'b1;
      prog_addr = AW'(1);
      prog_data = ~ref_mem[1];
      start = 1'b1;
      tick();
      prog_we = 1'b0;
      start = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL busy_err_set got=%b exp=1", err); end
      run_to_done(to);
      checks += 3;
      if (to || iss_data.size() != 4) begin
         errors++; $display("FAIL busy_count got=%0d exp=4", iss_data.size());
      end
      if (done_cnt != 1) begin errors++; $display("FAIL busy_done_cnt got=%0d exp=1", done_cnt); end
      if (err !== 1'b1) begin errors++; $display("FAIL busy_err_sticky got=%b exp=1", err); end
      launch(3, 0);
      run_to_done(to);
      checks++;
      if (to || iss_data.size() != 4 || iss_data[1] !== ref_mem[1]) begin
         errors++;
         $display("FAIL busy_mem_kept got=%h exp=%h", (iss_data.size() > 1) ? iss_data[1] : '0,
                  ref_mem[1]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL busy_err_clear got=%b exp=0", err); end
   endtask

   task automatic test_rst_midrun();
      bit to;
      int n = 0;
      launch(3, 1);
      while (iss_data.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (iss_data.size() < 2) begin errors++; $display("FAIL rst_mid_reach got=%0d exp=2", iss_data.size()); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 3;
      if (inst_v !== 1'b0) begin errors++; $display("FAIL rst_mid_inst_v got=%b exp=0", inst_v); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      if (pc !== '0) begin errors++; $display("FAIL rst_mid_pc got=%0d exp=0", pc); end
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL rst_mid_late_wb got=%b exp=1", err); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      launch(3, 0);
      run_to_done(to);
      checks += 2;
      if (to || iss_data.size() != 4) begin
         errors++; $display("FAIL rst_mid_rerun_count got=%0d exp=4", iss_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (iss_data[i] !== exp_q[i]) begin
               errors++; $display("FAIL rst_mid_rerun%0d got=%h exp=%h", i, iss_data[i], exp_q[i]);
            end
         end
      end
      if (done_cnt != 1 || err !== 1'b0) begin
         errors++; $display("FAIL rst_mid_rerun_done got=%0d err%b exp=1 err0", done_cnt, err);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      wb_lat = 0;
      write_word(0, {OP_ADDI, 29'($urandom)});
      launch(0, 4);
      run_to_done(to);
      wb_lat = WB_LATENCY;
      checks += 3;
      if (to || iss_data.size() != 5) begin
         errors++; $display("FAIL b2b_count got=%0d exp=5", iss_data.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (iss_data[i] !== ref_mem[0] || iss_cyc[i] != start_cyc + 2 + i) begin
               errors++; $display("FAIL b2b_issue%0d got=%h exp=%h", i, iss_data[i], ref_mem[0]);
            end
         end
      end
      if (done_cnt != 1 || iss_cyc.size() == 0 || done_cyc != iss_cyc[iss_cyc.size()-1] + 2) begin
         errors++; $display("FAIL b2b_done got=%0d@%0d exp=1", done_cnt, done_cyc);
      end
      if (err !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b exp=0", err); end
   endtask

   initial begin
      rst = 1'b1;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      start = 1'b0;
      end_addr = '0;
      loop_cnt = '0;
      stall = 1'b0;
      wb_v = 1'b0;
      test_reset();
      test_single_pass();
      test_loop();
      test_stall();
      test_random();
      test_busy_err();
      test_rst_midrun();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
